// File: rtl/transformer_sched.sv
// Two-requester round-robin scheduler around a shared combinational transformer.
// Optional per-requester accept counters are enabled with TRANSFORMER_SCHED_PERF_EN.
module transformer_sched #(
  parameter int TAG_W      = 4,
  parameter int FIFO_DEPTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid_i,
  input  logic [255:0]     req0_data_i,
  input  logic [TAG_W-1:0] req0_tag_i,
  output logic             req0_ready_o,
  input  logic             req1_valid_i,
  input  logic [255:0]     req1_data_i,
  input  logic [TAG_W-1:0] req1_tag_i,
  output logic             req1_ready_o,
  output logic [255:0]     xf_data_o,
  input  logic [255:0]     xf_data_i,
  output logic             out_valid_o,
  output logic [255:0]     out_data_o,
  output logic [TAG_W-1:0] out_tag_o,
  output logic             out_src_o,
  input  logic             out_ready_i,
  output logic             busy_o
`ifdef TRANSFORMER_SCHED_PERF_EN
  ,
  output logic [31:0]      perf_cnt0_o,
  output logic [31:0]      perf_cnt1_o
`endif
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W:0]   DEPTH_C  = (CNT_W + 1)'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FIFO_DEPTH - 1);

  logic             r_s1_valid;
  logic [255:0]     r_s1_data;
  logic [TAG_W-1:0] r_s1_tag;
  logic             r_s1_src;
  logic             r_rr;

  logic [255:0]     r_fifo_data [FIFO_DEPTH];
  logic [TAG_W-1:0] r_fifo_tag  [FIFO_DEPTH];
  logic             r_fifo_src  [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic [CNT_W:0]   w_occ;
  logic             w_room;
  logic             w_grant0;
  logic             w_grant1;
  logic             w_accept0;
  logic             w_accept1;
  logic             w_accept;
  logic             w_push;
  logic             w_pop;

  function automatic logic [PTR_W-1:0] f_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  // Credit check uses registered occupancy only, so out_ready_i never reaches the readies.
  assign w_occ     = {1'b0, r_count} + (CNT_W + 1)'(r_s1_valid);
  assign w_room    = w_occ < DEPTH_C;
  assign w_grant0  = req0_valid_i & (~req1_valid_i | ~r_rr);
  assign w_grant1  = req1_valid_i & (~req0_valid_i | r_rr);
  assign w_accept0 = ~rst & w_room & w_grant0;
  assign w_accept1 = ~rst & w_room & w_grant1;
  assign w_accept  = w_accept0 | w_accept1;
  assign w_push    = r_s1_valid;
  assign w_pop     = (r_count != '0) & out_ready_i;

  assign req0_ready_o = w_accept0;
  assign req1_ready_o = w_accept1;
  assign xf_data_o    = (r_s1_valid & ~rst) ? r_s1_data : '0;
  assign out_valid_o  = ~rst & (r_count != '0);
  assign out_data_o   = r_fifo_data[r_rd_ptr];
  assign out_tag_o    = r_fifo_tag[r_rd_ptr];
  assign out_src_o    = r_fifo_src[r_rd_ptr];
  assign busy_o       = ~rst & (r_s1_valid | (r_count != '0));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_rr       <= 1'b0;
    end else begin
      r_s1_valid <= w_accept;
      if (w_accept0)      r_rr <= 1'b1;
      else if (w_accept1) r_rr <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_s1_data <= w_accept1 ? req1_data_i : req0_data_i;
      r_s1_tag  <= w_accept1 ? req1_tag_i : req0_tag_i;
      r_s1_src  <= w_accept1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= f_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= f_inc(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_data[r_wr_ptr] <= xf_data_i;
      r_fifo_tag[r_wr_ptr]  <= r_s1_tag;
      r_fifo_src[r_wr_ptr]  <= r_s1_src;
    end
  end

`ifdef TRANSFORMER_SCHED_PERF_EN
  logic [31:0] r_perf_cnt0;
  logic [31:0] r_perf_cnt1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_cnt0 <= '0;
      r_perf_cnt1 <= '0;
    end else begin
      if (w_accept0 && (r_perf_cnt0 != '1)) r_perf_cnt0 <= r_perf_cnt0 + 32'd1;
      if (w_accept1 && (r_perf_cnt1 != '1)) r_perf_cnt1 <= r_perf_cnt1 + 32'd1;
    end
  end

  assign perf_cnt0_o = r_perf_cnt0;
  assign perf_cnt1_o = r_perf_cnt1;
`endif

endmodule

// File: tb/tb_transformer_sched.sv
// Directed self-checking bench for transformer_sched; the transformer is a rotate-xor model.
module tb_transformer_sched;

  localparam int TAG_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             req0_valid_i, req1_valid_i;
  logic [255:0]     req0_data_i, req1_data_i;
  logic [TAG_W-1:0] req0_tag_i, req1_tag_i;
  logic             req0_ready_o, req1_ready_o;
  logic [255:0]     xf_data_o, xf_data_i;
  logic             out_valid_o;
  logic [255:0]     out_data_o;
  logic [TAG_W-1:0] out_tag_o;
  logic             out_src_o;
  logic             out_ready_i;
  logic             busy_o;
`ifdef TRANSFORMER_SCHED_PERF_EN
  logic [31:0]      perf_cnt0_o, perf_cnt1_o;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  function automatic logic [255:0] xf(input logic [255:0] x);
    return {x[254:0], x[255]} ^ 256'h5A;
  endfunction

  assign xf_data_i = xf(xf_data_o);

  transformer_sched #(.TAG_W(TAG_W), .FIFO_DEPTH(3)) dut (
    .clk(clk), .rst(rst),
    .req0_valid_i(req0_valid_i), .req0_data_i(req0_data_i), .req0_tag_i(req0_tag_i),
    .req0_ready_o(req0_ready_o),
    .req1_valid_i(req1_valid_i), .req1_data_i(req1_data_i), .req1_tag_i(req1_tag_i),
    .req1_ready_o(req1_ready_o),
    .xf_data_o(xf_data_o), .xf_data_i(xf_data_i),
    .out_valid_o(out_valid_o), .out_data_o(out_data_o), .out_tag_o(out_tag_o),
    .out_src_o(out_src_o), .out_ready_i(out_ready_i), .busy_o(busy_o)
`ifdef TRANSFORMER_SCHED_PERF_EN
    , .perf_cnt0_o(perf_cnt0_o), .perf_cnt1_o(perf_cnt1_o)
`endif
  );

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req0_valid_i = 1'b0; req1_valid_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    req0_valid_i = 1'b1; req1_valid_i = 1'b1; out_ready_i = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({req0_ready_o, req1_ready_o} !== 2'b00) begin
      n_fail++; $display("FAIL reset_ready got=%b exp=00", {req0_ready_o, req1_ready_o});
    end
    n_tests++;
    if ({out_valid_o, busy_o} !== 2'b00) begin
      n_fail++; $display("FAIL reset_valid_busy got=%b exp=00", {out_valid_o, busy_o});
    end
    n_tests++;
    if (xf_data_o !== 256'h0) begin
      n_fail++; $display("FAIL reset_xf_data got=%h exp=0", xf_data_o);
    end
    req0_valid_i = 1'b0; req1_valid_i = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    out_ready_i = 1'b1;
    @(negedge clk);
    req0_valid_i = 1'b1; req0_data_i = 256'h1; req0_tag_i = 4'd3;
    #1;
    n_tests++;
    if ({req0_ready_o, req1_ready_o} !== 2'b10) begin
      n_fail++; $display("FAIL single_ready got=%b exp=10", {req0_ready_o, req1_ready_o});
    end
    @(negedge clk);
    req0_valid_i = 1'b0;
    n_tests++;
    if (xf_data_o !== 256'h1 || out_valid_o !== 1'b0 || busy_o !== 1'b1) begin
      n_fail++; $display("FAIL single_s1 got xf=%h ov=%b busy=%b exp xf=1 ov=0 busy=1",
                         xf_data_o, out_valid_o, busy_o);
    end
    @(negedge clk);
    n_tests++;
    if (out_valid_o !== 1'b1 || out_data_o !== xf(256'h1) || out_tag_o !== 4'd3 || out_src_o !== 1'b0) begin
      n_fail++; $display("FAIL single_out got ov=%b d=%h tag=%0d src=%b exp ov=1 d=%h tag=3 src=0",
                         out_valid_o, out_data_o, out_tag_o, out_src_o, xf(256'h1));
    end
    @(negedge clk);
    n_tests++;
    if (out_valid_o !== 1'b0 || busy_o !== 1'b0 || xf_data_o !== 256'h0) begin
      n_fail++; $display("FAIL single_idle got ov=%b busy=%b xf=%h exp 0 0 0", out_valid_o, busy_o, xf_data_o);
    end
  endtask

  task automatic test_back_to_back();
    logic [255:0]     e_d [10];
    logic [TAG_W-1:0] e_t [10];
    logic             e_s [10];
    do_reset();
    out_ready_i = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        n_tests++;
        if (out_valid_o !== 1'b1 || out_data_o !== xf(e_d[i-2]) || out_tag_o !== e_t[i-2] ||
            out_src_o !== e_s[i-2]) begin
          n_fail++; $display("FAIL b2b_out[%0d] got ov=%b d=%h tag=%0d src=%b exp ov=1 d=%h tag=%0d src=%b",
                             i-2, out_valid_o, out_data_o, out_tag_o, out_src_o, xf(e_d[i-2]), e_t[i-2], e_s[i-2]);
        end
      end
      if (i < 10) begin
        req0_valid_i = 1'b1; req0_data_i = 256'(32'h100 + i); req0_tag_i = 4'(i);
        req1_valid_i = 1'b1; req1_data_i = 256'(32'h200 + i); req1_tag_i = 4'(15 - i);
        e_s[i] = (i % 2 == 1);
        e_d[i] = e_s[i] ? req1_data_i : req0_data_i;
        e_t[i] = e_s[i] ? req1_tag_i : req0_tag_i;
        #1;
        n_tests++;
        if ({req0_ready_o, req1_ready_o} !== {~e_s[i], e_s[i]}) begin
          n_fail++; $display("FAIL b2b_grant[%0d] got=%b exp=%b", i, {req0_ready_o, req1_ready_o}, {~e_s[i], e_s[i]});
        end
      end else begin
        req0_valid_i = 1'b0; req1_valid_i = 1'b0;
      end
    end
    @(negedge clk);
    n_tests++;
    if (out_valid_o !== 1'b0 || busy_o !== 1'b0) begin
      n_fail++; $display("FAIL b2b_drained got ov=%b busy=%b exp 0 0", out_valid_o, busy_o);
    end
  endtask

  task automatic test_backpressure();
    logic [255:0] e_d [3];
    logic [1:0]   exp_rdy;
    int           n_acc = 0;
    do_reset();
    out_ready_i = 1'b0;
    e_d[0] = 256'h1000; e_d[1] = 256'h2001; e_d[2] = 256'h1002;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c >= 2) begin
        n_tests++;
        if (out_valid_o !== 1'b1 || out_data_o !== xf(e_d[0]) || out_tag_o !== 4'd0 || out_src_o !== 1'b0) begin
          n_fail++; $display("FAIL bp_head_stable[%0d] got ov=%b d=%h tag=%0d src=%b exp ov=1 d=%h tag=0 src=0",
                             c, out_valid_o, out_data_o, out_tag_o, out_src_o, xf(e_d[0]));
        end
      end
      req0_valid_i = 1'b1; req0_data_i = 256'(32'h1000 + c); req0_tag_i = 4'(c);
      req1_valid_i = 1'b1; req1_data_i = 256'(32'h2000 + c); req1_tag_i = 4'(8 + c);
      exp_rdy = (c == 0 || c == 2) ? 2'b10 : (c == 1) ? 2'b01 : 2'b00;
      #1;
      if (req0_ready_o || req1_ready_o) n_acc++;
      n_tests++;
      if ({req0_ready_o, req1_ready_o} !== exp_rdy) begin
        n_fail++; $display("FAIL bp_ready[%0d] got=%b exp=%b", c, {req0_ready_o, req1_ready_o}, exp_rdy);
      end
    end
    n_tests++;
    if (n_acc !== 3) begin
      n_fail++; $display("FAIL bp_accept_count got=%0d exp=3", n_acc);
    end
    @(negedge clk);
    req0_valid_i = 1'b0; req1_valid_i = 1'b0; out_ready_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      n_tests++;
      if (out_valid_o !== 1'b1 || out_data_o !== xf(e_d[k]) || out_src_o !== (k == 1) ||
          out_tag_o !== ((k == 1) ? 4'd9 : 4'(k))) begin
        n_fail++; $display("FAIL bp_drain[%0d] got ov=%b d=%h tag=%0d src=%b exp d=%h",
                           k, out_valid_o, out_data_o, out_tag_o, out_src_o, xf(e_d[k]));
      end
      @(negedge clk);
    end
    n_tests++;
    if (out_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL bp_empty got ov=%b exp=0", out_valid_o);
    end
  endtask

  task automatic test_reset_flush();
    do_reset();
    out_ready_i = 1'b0;
    @(negedge clk);
    req0_valid_i = 1'b1; req0_data_i = 256'hAAA; req0_tag_i = 4'd1;
    @(negedge clk);
    req0_data_i = 256'hBBB; req0_tag_i = 4'd2;
    @(negedge clk);
    req0_valid_i = 1'b0;
    n_tests++;
    if (busy_o !== 1'b1 || out_valid_o !== 1'b1) begin
      n_fail++; $display("FAIL flush_pre got busy=%b ov=%b exp 1 1", busy_o, out_valid_o);
    end
    rst = 1'b1;
    #1;
    n_tests++;
    if (out_valid_o !== 1'b0 || busy_o !== 1'b0) begin
      n_fail++; $display("FAIL flush_during_rst got ov=%b busy=%b exp 0 0", out_valid_o, busy_o);
    end
    @(negedge clk);
    rst = 1'b0;
    n_tests++;
    if (out_valid_o !== 1'b0 || busy_o !== 1'b0) begin
      n_fail++; $display("FAIL flush_after_rst got ov=%b busy=%b exp 0 0", out_valid_o, busy_o);
    end
    req0_valid_i = 1'b1; req0_data_i = 256'hCCC; req0_tag_i = 4'd5;
    req1_valid_i = 1'b1; req1_data_i = 256'hDDD; req1_tag_i = 4'd6;
    out_ready_i = 1'b1;
    #1;
    n_tests++;
    if ({req0_ready_o, req1_ready_o} !== 2'b10) begin
      n_fail++; $display("FAIL flush_grant got=%b exp=10", {req0_ready_o, req1_ready_o});
    end
    @(negedge clk);
    req0_valid_i = 1'b0; req1_valid_i = 1'b0;
    n_tests++;
    if (out_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL flush_stale got ov=%b d=%h exp ov=0", out_valid_o, out_data_o);
    end
    @(negedge clk);
    n_tests++;
    if (out_valid_o !== 1'b1 || out_data_o !== xf(256'hCCC) || out_tag_o !== 4'd5 || out_src_o !== 1'b0) begin
      n_fail++; $display("FAIL flush_new got ov=%b d=%h tag=%0d src=%b exp ov=1 d=%h tag=5 src=0",
                         out_valid_o, out_data_o, out_tag_o, out_src_o, xf(256'hCCC));
    end
    @(negedge clk);
    n_tests++;
    if (out_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL flush_end got ov=%b d=%h exp ov=0", out_valid_o, out_data_o);
    end
  endtask

`ifdef TRANSFORMER_SCHED_PERF_EN
  task automatic test_perf();
    do_reset();
    out_ready_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      req0_valid_i = (i < 5); req0_data_i = 256'(i); req0_tag_i = 4'(i);
      req1_valid_i = (i >= 5); req1_data_i = 256'(i); req1_tag_i = 4'(i);
    end
    @(negedge clk);
    req0_valid_i = 1'b0; req1_valid_i = 1'b0;
    n_tests++;
    if (perf_cnt0_o !== 32'd5 || perf_cnt1_o !== 32'd3) begin
      n_fail++; $display("FAIL perf_counts got=%0d/%0d exp=5/3", perf_cnt0_o, perf_cnt1_o);
    end
    force dut.r_perf_cnt0 = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.r_perf_cnt0;
    req0_valid_i = 1'b1;
    @(negedge clk);
    req0_valid_i = 1'b0;
    @(negedge clk);
    n_tests++;
    if (perf_cnt0_o !== 32'hFFFF_FFFF || perf_cnt1_o !== 32'd3) begin
      n_fail++; $display("FAIL perf_saturate got=%h/%0d exp=ffffffff/3", perf_cnt0_o, perf_cnt1_o);
    end
  endtask
`endif

  initial begin
    rst = 1'b1;
    req0_valid_i = 1'b0; req1_valid_i = 1'b0;
    req0_data_i = '0; req1_data_i = '0;
    req0_tag_i = '0; req1_tag_i = '0;
    out_ready_i = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_reset_flush();
`ifdef TRANSFORMER_SCHED_PERF_EN
    test_perf();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
